// File: rtl/bp_cce_pkg.sv
// Shared CCE types: stall-unit FSM states and cause-vector layout.
// Offsets are functions of the queue/FU counts so every user agrees.
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_stall_run   = 2'd0,
    e_stall_stall = 2'd1,
    e_stall_hung  = 2'd2
  } bp_cce_stall_state_e;

  // Cause vector, LSB first:
  // src queues | dst queues | wfq | fu hazards | dir busy
  function automatic int stall_src_off();
    return 0;
  endfunction

  function automatic int stall_dst_off(int n_src);
    return n_src;
  endfunction

  function automatic int stall_wfq_off(int n_src, int n_dst);
    return n_src + n_dst;
  endfunction

  function automatic int stall_fu_off(int n_src, int n_dst);
    return n_src + n_dst + 1;
  endfunction

  function automatic int stall_dir_off(int n_src, int n_dst, int n_fu);
    return n_src + n_dst + n_fu + 1;
  endfunction

  function automatic int stall_cause_w(int n_src, int n_dst, int n_fu);
    return n_src + n_dst + n_fu + 2;
  endfunction

endpackage

// File: rtl/bp_cce_stall_watchdog.sv
// Stall episode tracker: consecutive-stall counter, RUN/STALL/HUNG FSM
// and first-cause latch. Ports: stall_i/cause_code_i in, cause/timeout out.
module bp_cce_stall_watchdog
  import bp_cce_pkg::*;
#(
  parameter int timeout_p = 1024,
  parameter int code_w_p  = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                stall_i,
  input  logic [code_w_p-1:0] cause_code_i,
  input  logic                clr_timeout_i,
  output logic                stall_cause_v_o,
  output logic [code_w_p-1:0] stall_cause_o,
  output logic                timeout_o
);

  localparam int consec_w_lp = $clog2(timeout_p);
  localparam logic [consec_w_lp-1:0] last_lp =
    consec_w_lp'(timeout_p - 1);

  bp_cce_stall_state_e state_r, state_n;
  logic [consec_w_lp-1:0] consec_r, consec_n;
  logic [code_w_p-1:0] cause_r, cause_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_stall_run;
      consec_r <= '0;
      cause_r  <= '0;
    end else begin
      state_r  <= state_n;
      consec_r <= consec_n;
      cause_r  <= cause_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    cause_n  = cause_r;
    consec_n = stall_i ? consec_r + 1'b1 : '0;
    unique case (state_r)
      e_stall_run: begin
        if (stall_i) begin
          state_n = e_stall_stall;
          cause_n = cause_code_i;
        end
      end
      e_stall_stall: begin
        if (!stall_i)
          state_n = e_stall_run;
        else if (consec_r == last_lp)
          state_n = e_stall_hung;
      end
      e_stall_hung: begin
        // Ack wins over a live stall; the next cycle opens a new episode.
        if (clr_timeout_i) begin
          state_n  = e_stall_run;
          consec_n = '0;
        end
      end
      default: state_n = e_stall_run;
    endcase
  end

  assign stall_cause_v_o = (state_r != e_stall_run);
  assign stall_cause_o   = cause_r;
  assign timeout_o       = (state_r == e_stall_hung);

endmodule

// File: rtl/bp_cce_stall_unit.sv
// CCE stall detection: cause vector, priority-encoded cause, saturating
// stall counter, plus episode watchdog. stall_o is combinational.
module bp_cce_stall_unit
  import bp_cce_pkg::*;
#(
  parameter int num_src_q_p = 4,
  parameter int num_dst_q_p = 2,
  parameter int num_fu_p    = 3,
  parameter int cnt_width_p = 16,
  parameter int timeout_p   = 1024,
  localparam int cause_w_lp =
    stall_cause_w(num_src_q_p, num_dst_q_p, num_fu_p),
  localparam int cause_code_w_lp = $clog2(cause_w_lp)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [num_src_q_p-1:0]     src_yumi_req_i,
  input  logic [num_src_q_p-1:0]     src_v_i,
  input  logic [num_dst_q_p-1:0]     dst_v_req_i,
  input  logic [num_dst_q_p-1:0]     dst_ready_i,
  input  logic                       wfq_v_i,
  input  logic [num_src_q_p-1:0]     wfq_mask_i,
  input  logic [num_fu_p-1:0]        fu_use_i,
  input  logic [num_fu_p-1:0]        fu_busy_i,
  input  logic                       dir_busy_i,
  input  logic                       clr_stall_cnt_i,
  input  logic                       clr_timeout_i,
  output logic                       stall_o,
  output logic [cnt_width_p-1:0]     stall_count_o,
  output logic                       stall_cause_v_o,
  output logic [cause_code_w_lp-1:0] stall_cause_o,
  output logic                       timeout_o
);

  localparam int src_off_lp = stall_src_off();
  localparam int dst_off_lp = stall_dst_off(num_src_q_p);
  localparam int wfq_off_lp = stall_wfq_off(num_src_q_p, num_dst_q_p);
  localparam int fu_off_lp  = stall_fu_off(num_src_q_p, num_dst_q_p);
  localparam int dir_off_lp =
    stall_dir_off(num_src_q_p, num_dst_q_p, num_fu_p);
  localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;

  logic [cause_w_lp-1:0] cause;
  logic [cause_code_w_lp-1:0] cause_code;

  // Each status bit only matters when its request bit is set.
  assign cause[src_off_lp +: num_src_q_p] = src_yumi_req_i & ~src_v_i;
  assign cause[dst_off_lp +: num_dst_q_p] = dst_v_req_i & ~dst_ready_i;
  assign cause[wfq_off_lp] = wfq_v_i & ~|(wfq_mask_i & src_v_i);
  assign cause[fu_off_lp +: num_fu_p] = fu_use_i & fu_busy_i;
  assign cause[dir_off_lp] = dir_busy_i;

  assign stall_o = |cause;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    cause_code = '0;
    for (int i = cause_w_lp - 1; i >= 0; i--) begin
      if (cause[i])
        cause_code = cause_code_w_lp'(i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      stall_count_o <= '0;
    else if (clr_stall_cnt_i)
      stall_count_o <= '0;
    else if (stall_o && (stall_count_o != cnt_max_lp))
      stall_count_o <= stall_count_o + 1'b1;
  end

  bp_cce_stall_watchdog #(
    .timeout_p (timeout_p),
    .code_w_p  (cause_code_w_lp)
  ) u_watchdog (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .stall_i         (stall_o),
    .cause_code_i    (cause_code),
    .clr_timeout_i   (clr_timeout_i),
    .stall_cause_v_o (stall_cause_v_o),
    .stall_cause_o   (stall_cause_o),
    .timeout_o       (timeout_o)
  );

endmodule

// File: tb/tb_bp_cce_stall_unit.sv
// Bench for bp_cce_stall_unit: default instance plus a small one
// (4-bit counter, timeout 8), both checked against an episode model.
module tb_bp_cce_stall_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] src_yumi_req, src_v, wfq_mask;
  logic [1:0] dst_v_req, dst_ready;
  logic [2:0] fu_use, fu_busy;
  logic wfq_v, dir_busy, clr_cnt, clr_to;

  logic        b_stall, b_cv, b_to;
  logic [15:0] b_cnt;
  logic [3:0]  b_cause;
  logic        s_stall, s_cv, s_to;
  logic [3:0]  s_cnt;
  logic [3:0]  s_cause;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_cce_stall_unit u_big (
    .clk_i(clk), .reset_n_i(rst_n),
    .src_yumi_req_i(src_yumi_req), .src_v_i(src_v),
    .dst_v_req_i(dst_v_req), .dst_ready_i(dst_ready),
    .wfq_v_i(wfq_v), .wfq_mask_i(wfq_mask),
    .fu_use_i(fu_use), .fu_busy_i(fu_busy),
    .dir_busy_i(dir_busy), .clr_stall_cnt_i(clr_cnt),
    .clr_timeout_i(clr_to), .stall_o(b_stall),
    .stall_count_o(b_cnt), .stall_cause_v_o(b_cv),
    .stall_cause_o(b_cause), .timeout_o(b_to)
  );

  bp_cce_stall_unit #(.cnt_width_p(4), .timeout_p(8)) u_small (
    .clk_i(clk), .reset_n_i(rst_n),
    .src_yumi_req_i(src_yumi_req), .src_v_i(src_v),
    .dst_v_req_i(dst_v_req), .dst_ready_i(dst_ready),
    .wfq_v_i(wfq_v), .wfq_mask_i(wfq_mask),
    .fu_use_i(fu_use), .fu_busy_i(fu_busy),
    .dir_busy_i(dir_busy), .clr_stall_cnt_i(clr_cnt),
    .clr_timeout_i(clr_to), .stall_o(s_stall),
    .stall_count_o(s_cnt), .stall_cause_v_o(s_cv),
    .stall_cause_o(s_cause), .timeout_o(s_to)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // First reason in the documented order, or -1 when nothing stalls.
  function automatic int cause_code();
    for (int i = 0; i < 4; i++)
      if (src_yumi_req[i] && !src_v[i]) return i;
    for (int j = 0; j < 2; j++)
      if (dst_v_req[j] && !dst_ready[j]) return 4 + j;
    if (wfq_v && ((wfq_mask & src_v) == 4'd0)) return 6;
    for (int k = 0; k < 3; k++)
      if (fu_use[k] && fu_busy[k]) return 7 + k;
    if (dir_busy) return 10;
    return -1;
  endfunction

  // Model: index 0 = default instance, 1 = small instance.
  int lim_t[2] = '{1024, 8};
  int lim_c[2] = '{65535, 15};
  int m_streak[2], m_cause[2], m_count[2];
  bit m_valid[2], m_hung[2];

  always @(posedge clk or negedge rst_n) begin : model
    int code;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_streak[d] = 0; m_cause[d] = 0; m_count[d] = 0;
        m_valid[d] = 0;  m_hung[d] = 0;
      end
    end else begin
      code = cause_code();
      for (int d = 0; d < 2; d++) begin
        if (clr_cnt) m_count[d] = 0;
        else if (code >= 0 && m_count[d] < lim_c[d]) m_count[d]++;
        if (m_hung[d]) begin
          if (clr_to) begin
            m_hung[d] = 0; m_valid[d] = 0; m_streak[d] = 0;
          end
        end else if (code >= 0) begin
          if (!m_valid[d]) begin
            m_valid[d] = 1; m_cause[d] = code; m_streak[d] = 1;
          end else begin
            m_streak[d]++;
            if (m_streak[d] == lim_t[d]) m_hung[d] = 1;
          end
        end else begin
          m_valid[d] = 0; m_streak[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int code;
    code = cause_code();
    chk("b_stall", b_stall, code >= 0);
    chk("s_stall", s_stall, code >= 0);
    chk("b_count", b_cnt, m_count[0]);
    chk("s_count", s_cnt, m_count[1]);
    chk("b_cause_v", b_cv, m_valid[0]);
    chk("s_cause_v", s_cv, m_valid[1]);
    chk("b_cause", b_cause, m_cause[0]);
    chk("s_cause", s_cause, m_cause[1]);
    chk("b_timeout", b_to, m_hung[0]);
    chk("s_timeout", s_to, m_hung[1]);
  end

  task automatic idle();
    src_yumi_req = '0; src_v = '0; wfq_mask = '0;
    dst_v_req = '0; dst_ready = '0; fu_use = '0; fu_busy = '0;
    wfq_v = 0; dir_busy = 0; clr_cnt = 0; clr_to = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int burst;
    rst_n = 0;
    idle();
    #13;
    chk("rst_count", b_cnt, 0);
    chk("rst_cause_v", b_cv, 0);
    chk("rst_timeout", b_to, 0);
    rst_n = 1;
    step(1);

    src_yumi_req = 4'b0001;
    #1 chk("c0_stall", b_stall, 1);
    step(1);
    chk("c0_cause_v", b_cv, 1);
    chk("c0_cause", b_cause, 0);
    src_v = 4'b0001;
    #1 chk("c0_release", b_stall, 0);
    step(1);
    chk("c0_end_v", b_cv, 0);
    chk("c0_count", b_cnt, 1);
    idle();
    step(1);

    wfq_v = 1; wfq_mask = 4'b0110; src_v = 4'b1001;
    #1 chk("wfq_stall", b_stall, 1);
    step(1);
    chk("wfq_cause", b_cause, 6);
    src_v = 4'b1101;
    #1 chk("wfq_release", b_stall, 0);
    step(1);
    idle();
    dst_v_req = 2'b10; dir_busy = 1;
    #1 chk("prio_stall", b_stall, 1);
    step(1);
    chk("prio_cause", b_cause, 5);
    idle();
    step(1);

    fu_use = 3'b010; fu_busy = 3'b011;
    #1 chk("fu_stall", b_stall, 1);
    step(1);
    chk("fu_cause", b_cause, 8);
    fu_use = 3'b100;
    #1 chk("fu_nostall", b_stall, 0);
    step(1);
    idle();

    clr_cnt = 1; step(1); clr_cnt = 0;
    dir_busy = 1;
    step(1023);
    chk("wd_1023", b_to, 0);
    step(1);
    chk("wd_1024", b_to, 1);
    chk("wd_cause", b_cause, 10);
    chk("wd_count", b_cnt, 1024);
    dir_busy = 0; clr_to = 1;
    step(1);
    chk("wd_clr", b_to, 0);
    chk("wd_clr_v", b_cv, 0);
    clr_to = 0;

    clr_cnt = 1; step(1); clr_cnt = 0;
    dir_busy = 1;
    step(20);
    chk("sat_15", s_cnt, 15);
    step(2);
    chk("sat_hold", s_cnt, 15);
    clr_cnt = 1; step(1);
    chk("sat_clr", s_cnt, 0);
    clr_cnt = 0; step(1);
    chk("sat_after", s_cnt, 1);
    dir_busy = 0; clr_to = 1; step(1); clr_to = 0;
    step(2);

    dir_busy = 1;
    step(1024);
    chk("rh_hung", b_to, 1);
    clr_cnt = 1; step(1); clr_cnt = 0;
    step(37);
    chk("rh_count", b_cnt, 37);
    chk("rh_to", b_to, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_to", b_to, 0);
    chk("ar_cv", b_cv, 0);
    chk("ar_count", b_cnt, 0);
    chk("ar_stall", b_stall, 1);
    #2 rst_n = 1;
    step(1023);
    chk("ar_1023", b_to, 0);
    step(1);
    chk("ar_1024", b_to, 1);
    dir_busy = 0; clr_to = 1; step(1); clr_to = 0;
    step(1);

    burst = 0;
    repeat (4000) begin
      if (burst > 0) begin
        burst--;
        dir_busy = 1;
      end else begin
        dir_busy = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 63) == 0) burst = $urandom_range(5, 20);
      end
      src_v        = 4'($urandom);
      src_yumi_req = 4'($urandom & $urandom & $urandom);
      dst_ready    = 2'($urandom);
      dst_v_req    = 2'($urandom & $urandom & $urandom);
      wfq_v        = ($urandom_range(0, 7) == 0);
      wfq_mask     = 4'($urandom);
      fu_use       = 3'($urandom & $urandom);
      fu_busy      = 3'($urandom & $urandom);
      clr_cnt      = ($urandom_range(0, 31) == 0);
      clr_to       = ($urandom_range(0, 7) == 0);
      step(1);
    end
    idle();
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
